// File: rtl/regfile_read_port.sv
// Registered dual-operand read port for the VLIW register file, with same-edge write bypass
// and a one-entry skid buffer so the request side never sees a combinational stall path.
module regfile_read_port #(
    parameter int NREG = 8,
    parameter int AW   = 3,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [AW-1:0]        req_addr_a,
    input  logic [AW-1:0]        req_addr_b,
    input  logic [NREG*DW-1:0]   rf_flat,
    input  logic                 wr_en,
    input  logic [NREG-1:0]      wr_dec,
    input  logic [DW-1:0]        wr_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DW-1:0]        rsp_data_a,
    output logic [DW-1:0]        rsp_data_b
);

    // Handshake: a transfer happens on a negedge where valid and ready are both high.
    // req_ready depends only on reset and the skid flop; rsp_valid only on a flop.
    // Once rsp_valid is high its data stays put until rsp_ready takes it.

    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_a_q, rsp_a_d;
    logic [DW-1:0] rsp_b_q, rsp_b_d;
    logic          skid_valid_q, skid_valid_d;
    logic [DW-1:0] skid_a_q, skid_a_d;
    logic [DW-1:0] skid_b_q, skid_b_d;

    logic          accept;
    logic          drain;
    logic [DW-1:0] word_a;
    logic [DW-1:0] word_b;

    // Addresses with no matching register fall through to zero, and bypass can only
    // fire for a decoder bit that actually exists.
    function automatic logic [DW-1:0] pick_word(
        input logic [AW-1:0]      addr,
        input logic [NREG*DW-1:0] rf,
        input logic               we,
        input logic [NREG-1:0]    dec,
        input logic [DW-1:0]      wd
    );
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < NREG; i++) begin
            if (addr == AW'(i)) begin
                w = (we && dec[i]) ? wd : rf[i*DW +: DW];
            end
        end
        return w;
    endfunction

    assign req_ready = reset & ~skid_valid_q;
    assign accept    = req_valid & req_ready;
    assign drain     = rsp_valid_q & rsp_ready;

    assign word_a = pick_word(req_addr_a, rf_flat, wr_en, wr_dec, wr_data);
    assign word_b = pick_word(req_addr_b, rf_flat, wr_en, wr_dec, wr_data);

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_a_d      = rsp_a_q;
        rsp_b_d      = rsp_b_q;
        skid_valid_d = skid_valid_q;
        skid_a_d     = skid_a_q;
        skid_b_d     = skid_b_q;

        if (skid_valid_q && (drain || !rsp_valid_q)) begin
            // req_ready is low whenever the skid is full, so no accept can collide here.
            rsp_valid_d  = 1'b1;
            rsp_a_d      = skid_a_q;
            rsp_b_d      = skid_b_q;
            skid_valid_d = 1'b0;
        end else if (accept && (!rsp_valid_q || drain)) begin
            rsp_valid_d = 1'b1;
            rsp_a_d     = word_a;
            rsp_b_d     = word_b;
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_a_d     = word_a;
            skid_b_d     = word_b;
        end else if (drain) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Updates share the register-file write edge so the bypass sees the same write.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_q  <= 1'b0;
            rsp_a_q      <= '0;
            rsp_b_q      <= '0;
            skid_valid_q <= 1'b0;
            skid_a_q     <= '0;
            skid_b_q     <= '0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_a_q      <= rsp_a_d;
            rsp_b_q      <= rsp_b_d;
            skid_valid_q <= skid_valid_d;
            skid_a_q     <= skid_a_d;
            skid_b_q     <= skid_b_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_data_a = rsp_a_q;
    assign rsp_data_b = rsp_b_q;

endmodule

// File: tb/tb_regfile_read_port.sv
// Bench for regfile_read_port: directed scenarios plus random traffic, checked by a
// queue-based scoreboard fed from a behavioural model of the register file.
module tb_regfile_read_port;

    localparam int NREG = 8;
    localparam int AW   = 4;
    localparam int DW   = 32;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 req_valid;
    logic                 req_ready;
    logic [AW-1:0]        req_addr_a;
    logic [AW-1:0]        req_addr_b;
    logic [NREG*DW-1:0]   rf_flat;
    logic                 wr_en;
    logic [NREG-1:0]      wr_dec;
    logic [DW-1:0]        wr_data;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DW-1:0]        rsp_data_a;
    logic [DW-1:0]        rsp_data_b;

    logic [DW-1:0]   rf_m [NREG];
    logic [2*DW-1:0] exp_q [$];
    logic            ready_exp = 1'b0;
    int              tests_run = 0;
    int              tests_failed = 0;

    regfile_read_port #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr_a (req_addr_a),
        .req_addr_b (req_addr_b),
        .rf_flat    (rf_flat),
        .wr_en      (wr_en),
        .wr_dec     (wr_dec),
        .wr_data    (wr_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data_a (rsp_data_a),
        .rsp_data_b (rsp_data_b)
    );

    // ---------------- clock / watchdog ----------------
    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // ---------------- helpers ----------------
    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endfunction

    // Reference rule: same-edge write wins, out-of-range reads are zero.
    function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] addr);
        int ai;
        ai = int'(addr);
        if (ai >= NREG) return '0;
        if (wr_en && wr_dec[ai]) return wr_data;
        return rf_m[ai];
    endfunction

    task automatic pack_rf();
        for (int i = 0; i < NREG; i++) rf_flat[i*DW +: DW] = rf_m[i];
    endtask

    // Advance to just after the next active (falling) edge and commit any write.
    task automatic next_cycle();
        @(negedge clk);
        #1;
        if (wr_en) begin
            for (int i = 0; i < NREG; i++) if (wr_dec[i]) rf_m[i] = wr_data;
        end
        wr_en = 1'b0;
        pack_rf();
    endtask

    task automatic wait_accept(input string name);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 16 && !got; k++) begin
            @(posedge clk);
            got = req_ready;
            next_cycle();
        end
        if (!got) check(name, 64'd0, 64'd1);
        req_valid = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] a, input logic [AW-1:0] b);
        req_valid  = 1'b1;
        req_addr_a = a;
        req_addr_b = b;
        wait_accept("issue_timeout");
    endtask

    // ---------------- scoreboard: monitor side ----------------
    always @(posedge clk) begin
        int n;
        if (reset) begin
            n = exp_q.size();
            check("req_ready_vs_model", {63'd0, req_ready}, {63'd0, n < 2});
            check("rsp_valid_vs_model", {63'd0, rsp_valid}, {63'd0, n > 0});
            if (rsp_valid && n > 0) begin
                check("rsp_data", {rsp_data_a, rsp_data_b}, exp_q[0]);
                if (rsp_ready) void'(exp_q.pop_front());
            end
            ready_exp = (n < 2);
        end else begin
            ready_exp = 1'b0;
        end
    end

    // ---------------- scoreboard: capture side ----------------
    always @(posedge clk) begin
        #2;
        if (reset && req_valid && ready_exp)
            exp_q.push_back({exp_word(req_addr_a), exp_word(req_addr_b)});
    end

    // ---------------- stimulus ----------------
    initial begin
        logic got;
        req_valid  = 1'b0;
        req_addr_a = '0;
        req_addr_b = '0;
        rsp_ready  = 1'b0;
        wr_en      = 1'b0;
        wr_dec     = '0;
        wr_data    = '0;
        for (int i = 0; i < NREG; i++) rf_m[i] = '0;
        pack_rf();

        #2;
        check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("reset_req_ready", {63'd0, req_ready}, 64'd0);
        check("reset_rsp_data", {rsp_data_a, rsp_data_b}, 64'd0);
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("release_req_ready", {63'd0, req_ready}, 64'd1);

        // T1: plain read, one-edge latency, then idle
        rf_m[3] = 32'h11;
        rf_m[5] = 32'h22;
        pack_rf();
        rsp_ready = 1'b1;
        issue(4'd3, 4'd5);
        @(posedge clk);
        check("t1_valid", {63'd0, rsp_valid}, 64'd1);
        check("t1_data", {rsp_data_a, rsp_data_b}, {32'h11, 32'h22});
        next_cycle();
        @(posedge clk);
        check("t1_idle", {63'd0, rsp_valid}, 64'd0);
        next_cycle();

        // T2: same-edge write bypass into both operands
        rf_m[2] = 32'h1;
        pack_rf();
        wr_en   = 1'b1;
        wr_dec  = 8'h04;
        wr_data = 32'hDEAD;
        issue(4'd2, 4'd2);
        @(posedge clk);
        check("t2_bypass", {rsp_data_a, rsp_data_b}, {32'hDEAD, 32'hDEAD});
        next_cycle();

        // T3: stall fills output and skid, third request held off
        rsp_ready = 1'b0;
        issue(4'd1, 4'd2);
        issue(4'd3, 4'd4);
        @(posedge clk);
        check("t3_full_ready", {63'd0, req_ready}, 64'd0);
        next_cycle();
        req_valid  = 1'b1;
        req_addr_a = 4'd5;
        req_addr_b = 4'd6;
        repeat (2) begin
            @(posedge clk);
            check("t3_held_off", {63'd0, req_ready}, 64'd0);
            next_cycle();
        end
        rsp_ready = 1'b1;
        wait_accept("t3_r3_timeout");
        repeat (4) next_cycle();

        // T4: back-to-back stream at one response per edge
        for (int k = 0; k < 4; k++) begin
            req_valid  = 1'b1;
            req_addr_a = AW'($urandom_range(0, NREG - 1));
            req_addr_b = AW'($urandom_range(0, NREG - 1));
            @(posedge clk);
            check("t4_ready", {63'd0, req_ready}, 64'd1);
            if (k > 0) check("t4_stream", {63'd0, rsp_valid}, 64'd1);
            next_cycle();
        end
        req_valid = 1'b0;
        @(posedge clk);
        check("t4_last", {63'd0, rsp_valid}, 64'd1);
        next_cycle();
        @(posedge clk);
        check("t4_done", {63'd0, rsp_valid}, 64'd0);
        next_cycle();

        // T5: reset pulse between edges discards both held entries
        rsp_ready = 1'b0;
        issue(4'd1, 4'd1);
        issue(4'd2, 4'd2);
        #1;
        reset = 1'b0;
        #1;
        check("t5_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("t5_req_ready", {63'd0, req_ready}, 64'd0);
        check("t5_rsp_data", {rsp_data_a, rsp_data_b}, 64'd0);
        exp_q.delete();
        #1;
        reset = 1'b1;
        #1;
        check("t5_release_ready", {63'd0, req_ready}, 64'd1);
        rf_m[7] = 32'h77;
        pack_rf();
        rsp_ready = 1'b1;
        issue(4'd7, 4'd0);
        @(posedge clk);
        check("t5_new_data", {rsp_data_a, rsp_data_b}, {32'h77, rf_m[0]});
        next_cycle();

        // T6: out-of-range address and snapshot semantics under stall
        rsp_ready = 1'b0;
        rf_m[1] = 32'h5;
        pack_rf();
        issue(4'd9, 4'd1);
        @(posedge clk);
        check("t6_oob_and_reg1", {rsp_data_a, rsp_data_b}, {32'h0, 32'h5});
        next_cycle();
        wr_en   = 1'b1;
        wr_dec  = 8'h02;
        wr_data = 32'h6;
        next_cycle();
        @(posedge clk);
        check("t6_snapshot", {rsp_data_a, rsp_data_b}, {32'h0, 32'h5});
        next_cycle();
        rsp_ready = 1'b1;
        repeat (2) next_cycle();

        // Random traffic; requests hold until accepted
        got = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!req_valid || got) begin
                req_valid  = ($urandom_range(0, 2) != 0);
                req_addr_a = AW'($urandom_range(0, (1 << AW) - 1));
                req_addr_b = ($urandom_range(0, 3) == 0) ? req_addr_a : AW'($urandom_range(0, (1 << AW) - 1));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            wr_en     = ($urandom_range(0, 1) != 0);
            wr_dec    = ($urandom_range(0, 4) == 0) ? NREG'($urandom) : NREG'(1 << $urandom_range(0, NREG - 1));
            wr_data   = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                rf_m[$urandom_range(0, NREG - 1)] = $urandom;
                pack_rf();
            end
            @(posedge clk);
            got = req_valid && req_ready;
            next_cycle();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (6) next_cycle();
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
